// File: rtl/mul_div_sequencer_if.sv
// Handshake, result and borrowed-ALU signals of the multiply/divide sequencer.
// The master is the EX-stage side: control unit plus the shared ALU.
interface mul_div_sequencer_if;
  logic        start;
  logic        op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [15:0] res_hi;
  logic [15:0] res_lo;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_bnegate;
  logic [2:0]  alu_op;
  logic [3:0]  alu_shamt;
  logic [15:0] alu_rez;
  logic        alu_carry;

  modport master (
    output start, op, opa, opb,
    output alu_rez, alu_carry,
    input  busy, done, div_zero,
    input  res_hi, res_lo,
    input  alu_a, alu_b, alu_bnegate,
    input  alu_op, alu_shamt
  );

  modport slave (
    input  start, op, opa, opb,
    input  alu_rez, alu_carry,
    output busy, done, div_zero,
    output res_hi, res_lo,
    output alu_a, alu_b, alu_bnegate,
    output alu_op, alu_shamt
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer.
// One shift-add or restoring-divide step per cycle through the shared ALU.
module mul_div_sequencer #(
  parameter logic [2:0] ALU_OP_ADD  = 3'b010,
  parameter logic [2:0] ALU_OP_IDLE = 3'b000
) (
  input logic               clk,
  input logic               rst_n,
  mul_div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_op;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic [15:0] r_opnd;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;
  logic [15:0] r_res_hi;
  logic [15:0] r_res_lo;

  logic [16:0] w_r17;
  logic        w_ok;
  logic [15:0] w_hi_nxt;
  logic [15:0] w_lo_nxt;
  logic [15:0] w_alu_a;
  logic [15:0] w_alu_b;
  logic        w_bneg;
  logic [2:0]  w_alu_op;

  // Divide works on the 17-bit partial remainder {hi, next dividend bit}.
  assign w_r17 = {r_hi, r_lo[15]};
  assign w_ok  = w_r17[16] | bus.alu_carry;

  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_bneg   = 1'b0;
    w_alu_op = ALU_OP_IDLE;
    if (r_state == S_RUN) begin
      w_alu_op = ALU_OP_ADD;
      if (r_op) begin
        w_alu_a = w_r17[15:0];
        w_alu_b = r_opnd;
        w_bneg  = 1'b1;
      end else begin
        w_alu_a = r_hi;
        w_alu_b = r_lo[0] ? r_opnd : 16'h0000;
      end
    end
  end

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op) begin
      w_hi_nxt = w_ok ? bus.alu_rez : w_r17[15:0];
      w_lo_nxt = {r_lo[14:0], w_ok};
    end else begin
      w_hi_nxt = {bus.alu_carry, bus.alu_rez[15:1]};
      w_lo_nxt = {bus.alu_rez[0], r_lo[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op   <= bus.op;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (bus.op && (bus.opb == 16'h0000)) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_dz     <= 1'b1;
              r_res_hi <= bus.opa;
              r_res_lo <= 16'hFFFF;
            end else begin
              r_state <= S_RUN;
              r_dz    <= 1'b0;
              r_hi    <= '0;
              r_lo    <= bus.op ? bus.opa : bus.opb;
              r_opnd  <= bus.op ? bus.opb : bus.opa;
            end
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_res_hi <= w_hi_nxt;
            r_res_lo <= w_lo_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_zero    = r_dz;
  assign bus.res_hi      = r_res_hi;
  assign bus.res_lo      = r_res_lo;
  assign bus.alu_a       = w_alu_a;
  assign bus.alu_b       = w_alu_b;
  assign bus.alu_bnegate = w_bneg;
  assign bus.alu_op      = w_alu_op;
  assign bus.alu_shamt   = 4'd0;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer with a behavioural 16-bit ALU.
// Expected results come from a plain arithmetic model queued at issue time.
module tb_mul_div_sequencer;

  logic clk;
  logic rst_n;
  mul_div_sequencer_if bus ();

  mul_div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_a}
                 + {1'b0, (bus.alu_bnegate ? ~bus.alu_b : bus.alu_b)}
                 + {16'd0, bus.alu_bnegate};
  assign bus.alu_rez   = alu_sum[15:0];
  assign bus.alu_carry = alu_sum[16];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_res[$];
  logic        q_dz[$];
  int          q_lat[$];

  task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    logic        dz;
    int          lat;
    if (!o) begin
      r = 32'(a) * 32'(b);
      dz = 1'b0;
      lat = 16;
    end else if (b == 16'h0000) begin
      r = {a, 16'hFFFF};
      dz = 1'b1;
      lat = 0;
    end else begin
      r = {a % b, a / b};
      dz = 1'b0;
      lat = 16;
    end
    q_res.push_back(r);
    q_dz.push_back(dz);
    q_lat.push_back(lat);
    bus.start = 1'b1;
    bus.op = o;
    bus.opa = a;
    bus.opb = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 1'($urandom);
    bus.opa = 16'($urandom);
    bus.opb = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output logic [31:0] res, output logic dz);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    res = {bus.res_hi, bus.res_lo};
    dz = bus.div_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.opa = '0;
    bus.opb = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div_zero});
    end
    n_cmp++;
    if ({bus.res_hi, bus.res_lo} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_res got %h want 0", {bus.res_hi, bus.res_lo});
    end
    n_cmp++;
    if ({bus.alu_a, bus.alu_b, bus.alu_bnegate, bus.alu_op, bus.alu_shamt} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_alu got a=%h b=%h op=%h", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [15:0] va[5];
    logic [15:0] vb[5];
    int lat;
    int el;
    logic [31:0] res;
    logic [31:0] er;
    logic dz;
    logic edz;
    va = '{16'h1234, 16'hFFFF, 16'h0000, 16'hABCD, 16'h8000};
    vb = '{16'h0010, 16'hFFFF, 16'h5555, 16'h0001, 16'h0002};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, va[i], vb[i]);
      n_cmp++;
      if ({bus.busy, bus.alu_op, bus.alu_bnegate, bus.alu_shamt} !== {1'b1, 3'b010, 1'b0, 4'd0}) begin
        n_err++;
        $display("FAIL mul_run_alu got busy=%b op=%b bneg=%b", bus.busy, bus.alu_op, bus.alu_bnegate);
      end
      wait_done(lat, res, dz);
      er = q_res.pop_front();
      edz = q_dz.pop_front();
      el = q_lat.pop_front();
      n_cmp++;
      if (lat !== el) begin
        n_err++;
        $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, el);
      end
      n_cmp++;
      if (res !== er || dz !== edz) begin
        n_err++;
        $display("FAIL mul_result[%0d] got %h dz=%b want %h dz=%b", i, res, dz, er, edz);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL mul_after_done got busy,done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_div();
    logic [15:0] va[6];
    logic [15:0] vb[6];
    int lat;
    int el;
    logic [31:0] res;
    logic [31:0] er;
    logic dz;
    logic edz;
    va = '{16'd100, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h1234, 16'd0};
    vb = '{16'd7, 16'h8001, 16'h0009, 16'h0001, 16'h1234, 16'd3};
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, va[i], vb[i]);
      n_cmp++;
      if ({bus.alu_op, bus.alu_bnegate, bus.alu_b} !== {3'b010, 1'b1, vb[i]}) begin
        n_err++;
        $display("FAIL div_run_alu got op=%b bneg=%b b=%h want b=%h", bus.alu_op, bus.alu_bnegate, bus.alu_b, vb[i]);
      end
      wait_done(lat, res, dz);
      er = q_res.pop_front();
      edz = q_dz.pop_front();
      el = q_lat.pop_front();
      n_cmp++;
      if (lat !== el) begin
        n_err++;
        $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, el);
      end
      n_cmp++;
      if (res !== er || dz !== edz) begin
        n_err++;
        $display("FAIL div_result[%0d] got %h dz=%b want %h dz=%b", i, res, dz, er, edz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    int el;
    logic [31:0] res;
    logic [31:0] er;
    logic dz;
    logic edz;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue(1'b1, 16'h1234, 16'h0000);
      else issue(1'b1, 16'd100, 16'd7);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL dz_busy[%0d] got %b want 1", i, bus.busy);
      end
      wait_done(lat, res, dz);
      er = q_res.pop_front();
      edz = q_dz.pop_front();
      el = q_lat.pop_front();
      n_cmp++;
      if (lat !== el) begin
        n_err++;
        $display("FAIL dz_latency[%0d] got %0d want %0d", i, lat, el);
      end
      n_cmp++;
      if (res !== er || dz !== edz) begin
        n_err++;
        $display("FAIL dz_result[%0d] got %h dz=%b want %h dz=%b", i, res, dz, er, edz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int el;
    int extra;
    logic [31:0] res;
    logic [31:0] er;
    logic dz;
    logic edz;
    issue(1'b0, 16'h00FF, 16'h0101);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op = 1'b1;
    bus.opa = 16'h7777;
    bus.opb = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, res, dz);
    er = q_res.pop_front();
    edz = q_dz.pop_front();
    el = q_lat.pop_front();
    n_cmp++;
    if (lat !== el - 5) begin
      n_err++;
      $display("FAIL ign_latency got %0d want %0d", lat, el - 5);
    end
    n_cmp++;
    if (res !== er || dz !== edz) begin
      n_err++;
      $display("FAIL ign_result got %h dz=%b want %h dz=%b", res, dz, er, edz);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL ign_extra_done got %0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int el;
    int seen;
    logic [31:0] res;
    logic [31:0] er;
    logic dz;
    logic edz;
    issue(1'b0, 16'h4321, 16'h0F0F);
    void'(q_res.pop_front());
    void'(q_dz.pop_front());
    void'(q_lat.pop_front());
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.res_hi, bus.res_lo} !== 34'h0) begin
      n_err++;
      $display("FAIL rstmid_state got busy=%b done=%b res=%h want 0", bus.busy, bus.done, {bus.res_hi, bus.res_lo});
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL rstmid_no_done got %0d want 0", seen);
    end
    issue(1'b0, 16'd3, 16'd5);
    wait_done(lat, res, dz);
    er = q_res.pop_front();
    edz = q_dz.pop_front();
    el = q_lat.pop_front();
    n_cmp++;
    if (lat !== el || res !== er || dz !== edz) begin
      n_err++;
      $display("FAIL rstmid_mul got lat=%0d res=%h want lat=%0d res=%h", lat, res, el, er);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int el;
    logic [31:0] res;
    logic [31:0] er;
    logic dz;
    logic edz;
    logic o;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 12; i++) begin
      o = 1'($urandom);
      a = 16'($urandom);
      b = (i % 4 == 3) ? 16'h0000 : 16'($urandom_range(0, 255) << (i % 9));
      issue(o, a, b);
      wait_done(lat, res, dz);
      er = q_res.pop_front();
      edz = q_dz.pop_front();
      el = q_lat.pop_front();
      n_cmp++;
      if (lat !== el || res !== er || dz !== edz) begin
        n_err++;
        $display("FAIL b2b[%0d] op=%b a=%h b=%h got lat=%0d res=%h dz=%b want lat=%0d res=%h dz=%b",
                 i, o, a, b, lat, res, dz, el, er, edz);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
